// File: rtl/tetris_grid_renderer_pkg.sv
// Shared playfield types and colour constants used by the game FSM and the grid renderer.
package tetrispkg;

  localparam int GRID_ROWS = 22;
  localparam int GRID_COLS = 10;

  localparam logic [15:0] GRID_LINE_COLOR = 16'h4208;

  typedef enum logic [2:0] {
    CL0 = 3'd0,
    CL1 = 3'd1,
    CL2 = 3'd2,
    CL3 = 3'd3,
    CL4 = 3'd4,
    CL5 = 3'd5,
    CL6 = 3'd6,
    CL7 = 3'd7
  } color_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } rend_state_t;

  localparam logic [15:0] PALETTE [0:7] = '{
    16'h0000, 16'h07FF, 16'h001F, 16'hFD20,
    16'hFFE0, 16'h07E0, 16'h801F, 16'hF800
  };

  // Counter width for a 0..range-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/tetris_grid_renderer_raster_counter.sv
// Handshake-advanced px -> col -> py -> row counter chain with frame position flags.
module raster_counter
  import tetrispkg::*;
#(
  parameter int CELL_PX   = 2,
  parameter int ROW_COUNT = 20,
  parameter int PX_W      = cnt_w(CELL_PX),
  parameter int ROW_W     = cnt_w(ROW_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [PX_W-1:0]  px,
  output logic [3:0]       col,
  output logic [PX_W-1:0]  py,
  output logic [ROW_W-1:0] row,
  output logic             sof,
  output logic             eol,
  output logic             eof
);

  logic [PX_W-1:0]  px_q, px_d;
  logic [3:0]       col_q, col_d;
  logic [PX_W-1:0]  py_q, py_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic px_last, col_last, py_last, row_last;

  assign px_last  = (px_q == PX_W'(CELL_PX - 1));
  assign col_last = (col_q == 4'(GRID_COLS - 1));
  assign py_last  = (py_q == PX_W'(CELL_PX - 1));
  assign row_last = (row_q == ROW_W'(ROW_COUNT - 1));

  always_comb begin
    px_d  = px_q;
    col_d = col_q;
    py_d  = py_q;
    row_d = row_q;
    if (clear) begin
      px_d  = '0;
      col_d = '0;
      py_d  = '0;
      row_d = '0;
    end else if (advance) begin
      if (!px_last) begin
        px_d = px_q + 1'b1;
      end else begin
        px_d = '0;
        if (!col_last) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          if (!py_last) begin
            py_d = py_q + 1'b1;
          end else begin
            py_d  = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q  <= '0;
      col_q <= '0;
      py_q  <= '0;
      row_q <= '0;
    end else begin
      px_q  <= px_d;
      col_q <= col_d;
      py_q  <= py_d;
      row_q <= row_d;
    end
  end

  assign px  = px_q;
  assign col = col_q;
  assign py  = py_q;
  assign row = row_q;
  assign sof = (px_q == '0) && (col_q == '0) && (py_q == '0) && (row_q == '0);
  assign eol = col_last && px_last;
  assign eof = eol && py_last && row_last;

endmodule

// File: rtl/tetris_grid_renderer.sv
// Snapshots the playfield on a frame request and streams the visible rows as scaled RGB565 pixels.
//   state     | meaning
//   ST_IDLE   | waiting for start; outputs quiet
//   ST_STREAM | presenting pixels, advancing on handshake
//   ST_DONE   | one-cycle frame_done pulse before returning to idle
module tetris_grid_renderer
  import tetrispkg::*;
#(
  parameter int CELL_PX    = 2,
  parameter int ROW_FIRST  = 1,
  parameter int ROW_COUNT  = 20,
  parameter int GRID_LINES = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][2:0]  grid_i,
  output logic                                      busy,
  output logic                                      pix_valid,
  input  logic                                      pix_ready,
  output logic [15:0]                               pix_data,
  output logic                                      pix_sof,
  output logic                                      pix_eol,
  output logic                                      pix_eof,
  output logic                                      frame_done
);

  localparam int PX_W  = cnt_w(CELL_PX);
  localparam int ROW_W = cnt_w(ROW_COUNT);

  rend_state_t state_q, state_d;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0][2:0] snap_q, snap_d;

  logic             cnt_clear;
  logic             handshake;
  logic [PX_W-1:0]  px, py;
  logic [3:0]       col;
  logic [ROW_W-1:0] row;
  logic             sof, eol, eof;

  logic [4:0] row_idx;
  color_t     cell_c;
  logic       grid_line;

  raster_counter #(
    .CELL_PX   (CELL_PX),
    .ROW_COUNT (ROW_COUNT)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (handshake),
    .px      (px),
    .col     (col),
    .py      (py),
    .row     (row),
    .sof     (sof),
    .eol     (eol),
    .eof     (eof)
  );

  assign pix_valid = (state_q == ST_STREAM);
  assign handshake = pix_valid && pix_ready;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cnt_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d    = grid_i;
          cnt_clear = 1'b1;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (handshake && eof) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
    end
  end

  // Pixel colour is a pure function of snapshot and counters, so it holds through stalls.
  assign row_idx   = 5'(ROW_FIRST) + 5'(row);
  assign cell_c    = color_t'(snap_q[row_idx][col]);
  assign grid_line = (GRID_LINES != 0) && (cell_c == CL0) && ((px == '0) || (py == '0));

  always_comb begin
    pix_data = 16'h0000;
    if (pix_valid) pix_data = grid_line ? GRID_LINE_COLOR : PALETTE[cell_c];
  end

  assign pix_sof    = pix_valid && sof;
  assign pix_eol    = pix_valid && eol;
  assign pix_eof    = pix_valid && eof;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_tetris_grid_renderer.sv
// Drives two renderers (plain and grid-lined) in lockstep against a pixel-index reference model.
module tb_tetris_grid_renderer;

  localparam int CELL_PX   = 2;
  localparam int ROW_FIRST = 1;
  localparam int ROW_COUNT = 20;
  localparam int W         = 10 * CELL_PX;
  localparam int H         = ROW_COUNT * CELL_PX;
  localparam int TOTAL     = W * H;

  logic clk = 1'b0;
  logic rst, start, pix_ready;
  logic [21:0][9:0][2:0] grid_i;

  logic        busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done;
  logic [15:0] pix_data;
  logic        busy_g, pix_valid_g, pix_sof_g, pix_eol_g, pix_eof_g, frame_done_g;
  logic [15:0] pix_data_g;

  logic [2:0]  model_grid [22][10];
  logic [15:0] ref_pal [8] = '{16'h0000, 16'h07FF, 16'h001F, 16'hFD20,
                               16'hFFE0, 16'h07E0, 16'h801F, 16'hF800};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tetris_grid_renderer dut (
    .clk(clk), .rst(rst), .start(start), .grid_i(grid_i),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .frame_done(frame_done)
  );

  tetris_grid_renderer #(.GRID_LINES(1)) dut_gl (
    .clk(clk), .rst(rst), .start(start), .grid_i(grid_i),
    .busy(busy_g), .pix_valid(pix_valid_g), .pix_ready(pix_ready), .pix_data(pix_data_g),
    .pix_sof(pix_sof_g), .pix_eol(pix_eol_g), .pix_eof(pix_eof_g), .frame_done(frame_done_g)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {data, sof, eol, eof} for pixel n of the raster.
  function automatic logic [18:0] model_pix(input int n, input bit gl);
    int line = n / W;
    int x    = n % W;
    logic [2:0]  ci = model_grid[ROW_FIRST + line / CELL_PX][x / CELL_PX];
    logic [15:0] d  = ref_pal[ci];
    if (gl && ci == 3'd0 && ((x % CELL_PX) == 0 || (line % CELL_PX) == 0)) d = 16'h4208;
    return {d, n == 0, x == W - 1, n == TOTAL - 1};
  endfunction

  task automatic set_cell(input int r, input int c, input logic [2:0] v);
    grid_i[r][c]    = v;
    model_grid[r][c] = v;
  endtask

  task automatic fill_grid(input logic [2:0] v);
    for (int r = 0; r < 22; r++)
      for (int c = 0; c < 10; c++) set_cell(r, c, v);
  endtask

  task automatic run_frame(input bit rnd, input int poke_at, input int abort_at);
    int n = 0;
    int cyc = 0;
    bit stalled = 0;
    bit poked = 0;
    logic [18:0] cur, cur_g, prev, prev_g;
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 32'(pix_valid), 32'd1);
    chk("first_valid_gl", 32'(pix_valid_g), 32'd1);
    chk("busy_stream", 32'(busy), 32'd1);
    while (n < TOTAL && cyc < 4 * TOTAL + 100) begin
      cur   = {pix_data, pix_sof, pix_eol, pix_eof};
      cur_g = {pix_data_g, pix_sof_g, pix_eol_g, pix_eof_g};
      if (stalled) begin
        chk("stall_hold", 32'(cur), 32'(prev));
        chk("stall_hold_gl", 32'(cur_g), 32'(prev_g));
      end
      if (!pix_valid || !pix_valid_g) begin
        chk("valid_in_stream", 32'({pix_valid, pix_valid_g}), 32'b11);
        break;
      end
      if (n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'({pix_valid, pix_valid_g}), 32'd0);
        chk("abort_busy", 32'({busy, busy_g}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("abort_no_done", 32'({frame_done, frame_done_g, pix_valid}), 32'd0);
        end
        return;
      end
      chk("pix", 32'(cur), 32'(model_pix(n, 1'b0)));
      chk("pix_gl", 32'(cur_g), 32'(model_pix(n, 1'b1)));
      if (n == poke_at && !poked) begin
        poked = 1;
        for (int r = 0; r < 22; r++)
          for (int c = 0; c < 10; c++) grid_i[r][c] = 3'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      pix_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      stalled = pix_valid && !pix_ready;
      prev = cur;
      prev_g = cur_g;
      if (pix_valid && pix_ready) n++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("pix_count", 32'(n), 32'(TOTAL));
    chk("done_pulse", 32'({frame_done, frame_done_g}), 32'b11);
    chk("done_valid", 32'(pix_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("after_done", 32'({frame_done, busy, pix_valid, busy_g, pix_valid_g}), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    grid_i = '0;
    fill_grid(3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", 32'({busy, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, frame_done}), 32'd0);
      chk("reset_idle_gl", 32'({busy_g, pix_valid_g, pix_data_g, pix_sof_g, pix_eol_g, pix_eof_g,
                               frame_done_g}), 32'd0);
    end

    // Empty grid: plain renderer all black, grid-lined one shows cell borders.
    run_frame(1'b0, -1, -1);

    // Two coloured corner cells; hidden rows 0 and 21 are filled to prove they never render.
    fill_grid(3'd0);
    set_cell(1, 0, 3'd4);
    set_cell(20, 9, 3'd7);
    for (int c = 0; c < 10; c++) begin
      set_cell(0, c, 3'd6);
      set_cell(21, c, 3'd6);
    end
    run_frame(1'b0, -1, -1);
    run_frame(1'b1, -1, -1);

    // Grid rewritten and start re-pulsed mid-frame: snapshot and current frame unaffected.
    run_frame(1'b0, 100, -1);
    fill_grid(3'd1);
    run_frame(1'b1, -1, -1);

    // Reset mid-frame, then a clean full frame.
    fill_grid(3'd0);
    set_cell(1, 0, 3'd4);
    set_cell(20, 9, 3'd7);
    set_cell(10, 5, 3'd3);
    run_frame(1'b1, -1, 300);
    run_frame(1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
